// File: rtl/peripheral_biu_pkg.sv
// AMBA3 AHB-Lite encodings shared by the peripheral bus interface units.
package peripheral_biu_pkg;
  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic [2:0] HSIZE_BYTE  = 3'b000;
  localparam logic [2:0] HSIZE_HWORD = 3'b001;
  localparam logic [2:0] HSIZE_WORD  = 3'b010;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;
endpackage

// File: rtl/peripheral_timer_pkg.sv
// Register map, CTRL layout and address/byte-lane helpers for the multi-channel timer.
package peripheral_timer_pkg;
  import peripheral_biu_pkg::*;

  // 9 decoded address bits so that channel 15 (0x100) is reachable
  localparam int DEC_AW = 9;

  localparam logic [3:0] INFO_OFF     = 4'h0;
  localparam logic [3:0] IPENDING_OFF = 4'h4;
  localparam logic [3:0] RUNNING_OFF  = 4'h8;

  localparam logic [DEC_AW-1:0] CH_BASE   = 9'h010;
  localparam logic [DEC_AW-1:0] CH_STRIDE = 9'h010;

  localparam logic [3:0] CTRL_OFF     = 4'h0;
  localparam logic [3:0] PRESCALE_OFF = 4'h4;
  localparam logic [3:0] COUNT_OFF    = 4'h8;
  localparam logic [3:0] RELOAD_OFF   = 4'hC;

  localparam int CTRL_EN      = 0;
  localparam int CTRL_ONESHOT = 1;
  localparam int CTRL_IE      = 2;

  typedef struct packed {
    logic ie;
    logic oneshot;
    logic en;
  } ctrl_t;

  function automatic logic glb_hit(input logic [DEC_AW-1:0] a);
    return a[DEC_AW-1:4] == '0;
  endfunction

  function automatic logic ch_hit(input logic [DEC_AW-1:0] a, input int n);
    return {a[DEC_AW-1:4], 4'h0} == DEC_AW'(CH_BASE + n * CH_STRIDE);
  endfunction

  function automatic logic [3:0] reg_off(input logic [DEC_AW-1:0] a);
    return {a[3:2], 2'b00};
  endfunction

  function automatic logic [3:0] byte_en(input logic [2:0] hsize, input logic [1:0] a);
    case (hsize)
      HSIZE_BYTE:  return 4'b0001 << a;
      HSIZE_HWORD: return a[1] ? 4'b1100 : 4'b0011;
      HSIZE_WORD:  return 4'b1111;
      default:     return 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] be_mask(input logic [3:0] be);
    logic [31:0] m;
    m = '0;
    for (int b = 0; b < 4; b++) m[b*8 +: 8] = {8{be[b]}};
    return m;
  endfunction
endpackage

// File: rtl/peripheral_timer_channel.sv
// One timer channel: prescaler, down-counter with reload, and the IDLE/RUN FSM.
module peripheral_timer_channel
  import peripheral_timer_pkg::*;
#(
  parameter int CNT_WIDTH = 32
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_ctrl_we,
  input  logic                 i_pre_we,
  input  logic                 i_cnt_we,
  input  logic                 i_rld_we,
  input  logic [CNT_WIDTH-1:0] i_wdata,
  output ctrl_t                o_ctrl,
  output logic [CNT_WIDTH-1:0] o_prescale,
  output logic [CNT_WIDTH-1:0] o_count,
  output logic [CNT_WIDTH-1:0] o_reload,
  output logic                 o_expire
);
  localparam int CW = CNT_WIDTH;

  typedef enum logic {ST_IDLE, ST_RUN} state_t;

  state_t        r_state;
  logic          r_oneshot;
  logic          r_ie;
  logic [CW-1:0] r_pcnt;
  logic [CW-1:0] r_prescale;
  logic [CW-1:0] r_count;
  logic [CW-1:0] r_reload;
  logic          w_tick;
  logic          w_expire;

  assign w_tick   = (r_state == ST_RUN) && (r_pcnt == '0);
  assign w_expire = w_tick && (r_count == '0);

  // A CTRL write in the same cycle as a one-shot expiry decides EN.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state   <= ST_IDLE;
      r_oneshot <= 1'b0;
      r_ie      <= 1'b0;
    end else begin
      if (i_ctrl_we) begin
        r_oneshot <= i_wdata[CTRL_ONESHOT];
        r_ie      <= i_wdata[CTRL_IE];
      end
      case (r_state)
        ST_IDLE: if (i_ctrl_we && i_wdata[CTRL_EN]) r_state <= ST_RUN;
        ST_RUN: begin
          if (i_ctrl_we)                  r_state <= i_wdata[CTRL_EN] ? ST_RUN : ST_IDLE;
          else if (w_expire && r_oneshot) r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_pcnt     <= '0;
      r_prescale <= '0;
      r_count    <= '0;
      r_reload   <= '0;
    end else begin
      if (i_pre_we) r_prescale <= i_wdata;
      if (i_rld_we) r_reload   <= i_wdata;

      // PRESCALE changes only land on pcnt at a reload point
      if (r_state != ST_RUN || w_tick) r_pcnt <= r_prescale;
      else                              r_pcnt <= r_pcnt - CW'(1);

      if (i_cnt_we)    r_count <= i_wdata;
      else if (w_tick) r_count <= (r_count == '0) ? r_reload : r_count - CW'(1);
    end
  end

  assign o_ctrl     = '{ie: r_ie, oneshot: r_oneshot, en: (r_state == ST_RUN)};
  assign o_prescale = r_prescale;
  assign o_count    = r_count;
  assign o_reload   = r_reload;
  assign o_expire   = w_expire;
endmodule

// File: rtl/peripheral_timer_multi_ahb.sv
// Multi-channel AHB-Lite timer: bus decode, byte-lane merge, read mux, pending and interrupt regs.
module peripheral_timer_multi_ahb
  import peripheral_biu_pkg::*;
  import peripheral_timer_pkg::*;
#(
  parameter int HADDR_SIZE = 32,
  parameter int HDATA_SIZE = 32,
  parameter int TIMERS     = 4,
  parameter int CNT_WIDTH  = 32
) (
  input  logic                  HRESETn,
  input  logic                  HCLK,
  input  logic                  HSEL,
  input  logic [HADDR_SIZE-1:0] HADDR,
  input  logic [HDATA_SIZE-1:0] HWDATA,
  input  logic                  HWRITE,
  input  logic [2:0]            HSIZE,
  input  logic [2:0]            HBURST,
  input  logic [3:0]            HPROT,
  input  logic [1:0]            HTRANS,
  input  logic                  HREADY,
  output logic [HDATA_SIZE-1:0] HRDATA,
  output logic                  HREADYOUT,
  output logic                  HRESP,
  output logic [TIMERS-1:0]     tint,
  output logic                  tint_any
);
  localparam int CW = CNT_WIDTH;

  logic                   w_acc;
  logic                   r_wr;
  logic [DEC_AW-1:0]      r_waddr;
  logic [3:0]             r_be;
  logic [TIMERS-1:0]      r_ipend;

  ctrl_t [TIMERS-1:0]          w_ctrl;
  logic  [TIMERS-1:0][CW-1:0]  w_pre;
  logic  [TIMERS-1:0][CW-1:0]  w_cnt;
  logic  [TIMERS-1:0][CW-1:0]  w_rld;
  logic  [TIMERS-1:0]          w_expire;
  logic  [TIMERS-1:0]          w_en;
  logic  [TIMERS-1:0]          w_ie;
  logic  [TIMERS-1:0]          w_ctrl_we;
  logic  [TIMERS-1:0]          w_pre_we;
  logic  [TIMERS-1:0]          w_cnt_we;
  logic  [TIMERS-1:0]          w_rld_we;
  logic                        w_ipend_we;
  logic  [TIMERS-1:0]          w_w1c;
  logic  [31:0]                w_old;
  logic  [31:0]                w_mask;
  logic  [31:0]                w_wdm;
  logic  [31:0]                w_merged;
  logic                        w_unused;

  assign w_unused  = ^{HBURST, HPROT, HADDR[HADDR_SIZE-1:DEC_AW]};
  assign HREADYOUT = 1'b1;
  assign HRESP     = HRESP_OKAY;

  assign w_acc = HREADY & HSEL & ((HTRANS == HTRANS_NONSEQ) | (HTRANS == HTRANS_SEQ));

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      r_wr    <= 1'b0;
      r_waddr <= '0;
      r_be    <= '0;
    end else if (HREADY) begin
      r_wr    <= w_acc & HWRITE;
      r_waddr <= HADDR[DEC_AW-1:0];
      r_be    <= byte_en(HSIZE, HADDR[1:0]);
    end
  end

  function automatic logic [31:0] rd_mux(input logic [DEC_AW-1:0] a);
    logic [31:0] d;
    d = '0;
    if (glb_hit(a)) begin
      case (reg_off(a))
        INFO_OFF:     d = {16'h0002, 8'h00, 8'(TIMERS)};
        IPENDING_OFF: d[TIMERS-1:0] = r_ipend;
        RUNNING_OFF:  d[TIMERS-1:0] = w_en;
        default:      d = '0;
      endcase
    end
    for (int n = 0; n < TIMERS; n++) begin
      if (ch_hit(a, n)) begin
        case (reg_off(a))
          CTRL_OFF:     d = 32'(w_ctrl[n]);
          PRESCALE_OFF: d[CW-1:0] = w_pre[n];
          COUNT_OFF:    d[CW-1:0] = w_cnt[n];
          RELOAD_OFF:   d[CW-1:0] = w_rld[n];
          default:      d = '0;
        endcase
      end
    end
    return d;
  endfunction

  // Partial writes keep the untouched bytes of the register's current value.
  always_comb begin
    w_old    = rd_mux(r_waddr);
    w_mask   = be_mask(r_be);
    w_wdm    = 32'(HWDATA) & w_mask;
    w_merged = (w_old & ~w_mask) | w_wdm;
  end

  always_comb begin
    w_ctrl_we  = '0;
    w_pre_we   = '0;
    w_cnt_we   = '0;
    w_rld_we   = '0;
    w_ipend_we = r_wr && glb_hit(r_waddr) && (reg_off(r_waddr) == IPENDING_OFF);
    for (int n = 0; n < TIMERS; n++) begin
      if (r_wr && ch_hit(r_waddr, n)) begin
        case (reg_off(r_waddr))
          CTRL_OFF:     w_ctrl_we[n] = 1'b1;
          PRESCALE_OFF: w_pre_we[n]  = 1'b1;
          COUNT_OFF:    w_cnt_we[n]  = 1'b1;
          RELOAD_OFF:   w_rld_we[n]  = 1'b1;
          default:      ;
        endcase
      end
    end
  end

  // W1C only clears bits from enabled byte lanes
  assign w_w1c = w_ipend_we ? w_wdm[TIMERS-1:0] : '0;

  for (genvar g = 0; g < TIMERS; g++) begin : g_ch
    peripheral_timer_channel #(.CNT_WIDTH(CW)) u_ch (
      .i_clk      (HCLK),
      .i_rst_n    (HRESETn),
      .i_ctrl_we  (w_ctrl_we[g]),
      .i_pre_we   (w_pre_we[g]),
      .i_cnt_we   (w_cnt_we[g]),
      .i_rld_we   (w_rld_we[g]),
      .i_wdata    (w_merged[CW-1:0]),
      .o_ctrl     (w_ctrl[g]),
      .o_prescale (w_pre[g]),
      .o_count    (w_cnt[g]),
      .o_reload   (w_rld[g]),
      .o_expire   (w_expire[g])
    );
    assign w_en[g] = w_ctrl[g].en;
    assign w_ie[g] = w_ctrl[g].ie;
  end

  // Expiry is OR'd in after the clear so it wins a same-cycle W1C.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      r_ipend  <= '0;
      tint     <= '0;
      tint_any <= 1'b0;
      HRDATA   <= '0;
    end else begin
      r_ipend  <= (r_ipend & ~w_w1c) | w_expire;
      tint     <= r_ipend & w_ie;
      tint_any <= |(r_ipend & w_ie);
      if (w_acc && !HWRITE) HRDATA <= HDATA_SIZE'(rd_mux(HADDR[DEC_AW-1:0]));
    end
  end
endmodule
